// File: rtl/scr_permutation_index_mc.sv
// Multi-channel permutation index register for the loop shuffler.
// One channel per hardware loop: latches an element count at loop setup and
// walks the permutation-table index once per retired loop-end instruction.
//
// state | meaning
// IDLE  | channel not running; index_o holds its last value
// RUN   | loop active; each hit steps the index, terminal hit ends the run
module scr_permutation_index_mc #(
  parameter int BITS_PER_ELEMENT = 7,
  parameter int NUM_LOOPS        = 2,
  parameter int ADDR_W           = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ADDR_W-1:0]                      pc_i,
  input  logic                                   pc_valid_i,
  input  logic [NUM_LOOPS*ADDR_W-1:0]            hwlp_end_addr_i,
  input  logic [NUM_LOOPS-1:0]                   start_i,
  input  logic [NUM_LOOPS*(BITS_PER_ELEMENT+1)-1:0] num_elements_i,
  input  logic [NUM_LOOPS-1:0]                   dir_i,
  input  logic [NUM_LOOPS-1:0]                   abort_i,
  output logic [NUM_LOOPS*BITS_PER_ELEMENT-1:0]  index_o,
  output logic [NUM_LOOPS-1:0]                   active_o,
  output logic [NUM_LOOPS-1:0]                   done_o
);

  localparam int BPE = BITS_PER_ELEMENT;
  localparam int CW  = BITS_PER_ELEMENT + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  for (genvar k = 0; k < NUM_LOOPS; k++) begin : g_ch
    state_t          state_q, state_d;
    logic [BPE-1:0]  index_q, index_d;
    logic [CW-1:0]   num_q, num_d;
    logic            dir_q, dir_d;
    logic            done_q, done_d;

    logic            hit;
    logic [CW-1:0]   n_in;
    logic [CW-1:0]   n_in_m1;
    logic [CW-1:0]   last_full;
    logic            terminal;

    // Loop-end match; pc 0 is never treated as a loop end so an unprogrammed
    // end address cannot fire.
    assign hit       = pc_valid_i && (pc_i == hwlp_end_addr_i[k*ADDR_W +: ADDR_W])
                       && (pc_i != '0);
    assign n_in      = num_elements_i[k*CW +: CW];
    assign n_in_m1   = n_in - 1'b1;
    assign last_full = num_q - 1'b1;
    // Terminal check precedes the step, so the index never wraps.
    assign terminal  = dir_q ? (index_q == last_full[BPE-1:0]) : (index_q == '0);

    // Next-state logic, priority abort > start > hit.
    always_comb begin
      state_d = state_q;
      index_d = index_q;
      num_d   = num_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
      if (abort_i[k]) begin
        if (state_q == RUN) state_d = IDLE;
      end else if (start_i[k]) begin
        if (n_in != '0) begin
          state_d = RUN;
          num_d   = n_in;
          dir_d   = dir_i[k];
          index_d = dir_i[k] ? '0 : n_in_m1[BPE-1:0];
        end
      end else if (hit && (state_q == RUN)) begin
        if (terminal) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          index_d = dir_q ? (index_q + 1'b1) : (index_q - 1'b1);
        end
      end
    end

    // Channel state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        index_q <= '0;
        num_q   <= '0;
        dir_q   <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        index_q <= index_d;
        num_q   <= num_d;
        dir_q   <= dir_d;
        done_q  <= done_d;
      end
    end

    assign index_o[k*BPE +: BPE] = index_q;
    assign active_o[k]           = (state_q == RUN);
    assign done_o[k]             = done_q;
  end

endmodule
